// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package definitions;

    typedef logic       Signal;
    typedef logic [4:0] RegAddr;

    typedef enum logic {RUN, MUL_BUSY} hz_mode_t;

    // A producer matches a source when it writes the register file,
    // its destination is not r0, and the addresses agree.
    function automatic Signal reg_match(input Signal we, input RegAddr rd, input RegAddr src);
        return we & (rd != '0) & (rd == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Compares one D/X source operand against the X and M destinations.
module fwd_match
    import definitions::*;
(
    input  logic [4:0] i_src_addr,
    input  logic       i_uses_src,
    input  logic [4:0] i_x_rd_addr,
    input  logic       i_x_reg_write,
    input  logic [4:0] i_m_rd_addr,
    input  logic       i_m_reg_write,
    output logic       o_match_x,
    output logic       o_match_m
);

    assign o_match_x = i_uses_src & reg_match(i_x_reg_write, i_x_rd_addr, i_src_addr);
    assign o_match_m = i_uses_src & reg_match(i_m_reg_write, i_m_rd_addr, i_src_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: forwarding selects, pipeline holds/flushes,
// multi-cycle multiply tracking and a stall-cycle counter.
module hazard_ctrl
    import definitions::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       dx_rs_addr,
    input  logic [4:0]       dx_rt_addr,
    input  logic             dx_uses_rs,
    input  logic             dx_uses_rt,
    input  logic             dx_is_mul,
    input  logic [4:0]       x_rd_addr,
    input  logic             x_reg_write,
    input  logic             x_mem_read,
    input  logic             x_branch_taken,
    input  logic [4:0]       m_rd_addr,
    input  logic             m_reg_write,
    input  logic             m_mem_req,
    input  logic             mem_ready,
    output logic             stall,
    output logic             fwdX_rs,
    output logic             fwdX_rt,
    output logic             fwdM_rs,
    output logic             fwdM_rt,
    output logic             hold_fd,
    output logic             hold_dx,
    output logic             hold_x,
    output logic             hold_m,
    output logic             bubble_m,
    output logic             flush_fd,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    hz_mode_t         r_mode;
    hz_mode_t         w_mode_nxt;
    logic [3:0]       r_mul_cnt;
    logic [3:0]       w_mul_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_mx_rs, w_mm_rs, w_mx_rt, w_mm_rt;
    logic w_lu, w_mem_wait;

    fwd_match u_match_rs (
        .i_src_addr    (dx_rs_addr),
        .i_uses_src    (dx_uses_rs),
        .i_x_rd_addr   (x_rd_addr),
        .i_x_reg_write (x_reg_write),
        .i_m_rd_addr   (m_rd_addr),
        .i_m_reg_write (m_reg_write),
        .o_match_x     (w_mx_rs),
        .o_match_m     (w_mm_rs)
    );

    fwd_match u_match_rt (
        .i_src_addr    (dx_rt_addr),
        .i_uses_src    (dx_uses_rt),
        .i_x_rd_addr   (x_rd_addr),
        .i_x_reg_write (x_reg_write),
        .i_m_rd_addr   (m_rd_addr),
        .i_m_reg_write (m_reg_write),
        .o_match_x     (w_mx_rt),
        .o_match_m     (w_mm_rt)
    );

    assign w_lu       = x_mem_read & (w_mx_rs | w_mx_rt);
    assign w_mem_wait = m_mem_req & ~mem_ready;
    assign stall_cycles = r_stall_cycles;

    // Mode, multiply countdown and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode         <= RUN;
            r_mul_cnt      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
            if (hold_fd)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    // Prioritised control decode and next-state logic.
    always_comb begin
        w_mode_nxt    = r_mode;
        w_mul_cnt_nxt = r_mul_cnt;
        stall    = 1'b0;
        fwdX_rs  = 1'b0;
        fwdX_rt  = 1'b0;
        fwdM_rs  = 1'b0;
        fwdM_rt  = 1'b0;
        hold_fd  = 1'b0;
        hold_dx  = 1'b0;
        hold_x   = 1'b0;
        hold_m   = 1'b0;
        bubble_m = 1'b0;
        flush_fd = 1'b0;
        if (!rst) begin
            fwdX_rs = w_mx_rs & ~x_mem_read;
            fwdX_rt = w_mx_rt & ~x_mem_read;
            fwdM_rs = w_mm_rs;
            fwdM_rt = w_mm_rt;
            if (w_mem_wait) begin
                hold_fd = 1'b1;
                hold_dx = 1'b1;
                hold_x  = 1'b1;
                hold_m  = 1'b1;
            end else if (r_mode == MUL_BUSY) begin
                hold_fd       = 1'b1;
                hold_dx       = 1'b1;
                hold_x        = 1'b1;
                bubble_m      = 1'b1;
                w_mul_cnt_nxt = r_mul_cnt - 4'd1;
                if (r_mul_cnt == 4'd1)
                    w_mode_nxt = RUN;
            end else if (x_branch_taken) begin
                flush_fd = 1'b1;
                stall    = 1'b1;
            end else if (w_lu) begin
                stall   = 1'b1;
                hold_fd = 1'b1;
                hold_dx = 1'b1;
            end else if (dx_is_mul && (MUL_LAT > 1)) begin
                w_mode_nxt    = MUL_BUSY;
                w_mul_cnt_nxt = MUL_INIT;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed sequences
// and randomized stimulus against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       is_mul;
        logic [4:0] xrd;
        logic       xw;
        logic       xmr;
        logic       br;
        logic [4:0] mrd;
        logic       mw;
        logic       mreq;
        logic       mrdy;
    } in_t;

    // {stall, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, hold_fd, hold_dx, hold_x, hold_m, bubble_m, flush_fd}
    typedef struct {
        in_t         v;
        logic [10:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] dx_rs_addr, dx_rt_addr, x_rd_addr, m_rd_addr;
    logic dx_uses_rs, dx_uses_rt, dx_is_mul, x_reg_write, x_mem_read, x_branch_taken;
    logic m_reg_write, m_mem_req, mem_ready;
    logic stall, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt;
    logic hold_fd, hold_dx, hold_x, hold_m, bubble_m, flush_fd;
    logic [31:0] stall_cycles;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: multiply cycles still to spend busy, and hold_fd count.
    int unsigned m_busy = 0;
    int unsigned m_cnt  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .dx_rs_addr(dx_rs_addr), .dx_rt_addr(dx_rt_addr),
        .dx_uses_rs(dx_uses_rs), .dx_uses_rt(dx_uses_rt), .dx_is_mul(dx_is_mul),
        .x_rd_addr(x_rd_addr), .x_reg_write(x_reg_write), .x_mem_read(x_mem_read),
        .x_branch_taken(x_branch_taken),
        .m_rd_addr(m_rd_addr), .m_reg_write(m_reg_write), .m_mem_req(m_mem_req),
        .mem_ready(mem_ready),
        .stall(stall), .fwdX_rs(fwdX_rs), .fwdX_rt(fwdX_rt),
        .fwdM_rs(fwdM_rs), .fwdM_rt(fwdM_rt),
        .hold_fd(hold_fd), .hold_dx(hold_dx), .hold_x(hold_x), .hold_m(hold_m),
        .bubble_m(bubble_m), .flush_fd(flush_fd), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        rst = v.rst; dx_rs_addr = v.rs; dx_rt_addr = v.rt;
        dx_uses_rs = v.uses_rs; dx_uses_rt = v.uses_rt; dx_is_mul = v.is_mul;
        x_rd_addr = v.xrd; x_reg_write = v.xw; x_mem_read = v.xmr; x_branch_taken = v.br;
        m_rd_addr = v.mrd; m_reg_write = v.mw; m_mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    function automatic logic writes_to(input logic we, input logic [4:0] rd, input logic use_src, input logic [4:0] a);
        return use_src && we && rd != 5'd0 && rd == a;
    endfunction

    function automatic logic is_lu(input in_t v);
        return v.xmr && (writes_to(v.xw, v.xrd, v.uses_rs, v.rs) || writes_to(v.xw, v.xrd, v.uses_rt, v.rt));
    endfunction

    function automatic logic [10:0] model_ctrl(input in_t v, input int unsigned busy);
        logic s, fxs, fxt, fms, fmt, hfd, hdx, hx, hm, bm, ffd;
        {s, fxs, fxt, fms, fmt, hfd, hdx, hx, hm, bm, ffd} = '0;
        if (!v.rst) begin
            fxs = writes_to(v.xw, v.xrd, v.uses_rs, v.rs) && !v.xmr;
            fxt = writes_to(v.xw, v.xrd, v.uses_rt, v.rt) && !v.xmr;
            fms = writes_to(v.mw, v.mrd, v.uses_rs, v.rs);
            fmt = writes_to(v.mw, v.mrd, v.uses_rt, v.rt);
            if (v.mreq && !v.mrdy) {hfd, hdx, hx, hm} = 4'b1111;
            else if (busy > 0) {hfd, hdx, hx, bm} = 4'b1111;
            else if (v.br) {ffd, s} = 2'b11;
            else if (is_lu(v)) {s, hfd, hdx} = 3'b111;
        end
        return {s, fxs, fxt, fms, fmt, hfd, hdx, hx, hm, bm, ffd};
    endfunction

    // One clock: drive, check mid-cycle, then advance the model at the edge.
    task automatic run_cycle(input string name, input in_t v, output logic [10:0] obs);
        logic [10:0] e;
        drive(v);
        @(negedge clk);
        e   = model_ctrl(v, m_busy);
        obs = {stall, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, hold_fd, hold_dx, hold_x, hold_m, bubble_m, flush_fd};
        chk({name, "_ctrl"}, 32'(obs), 32'(e));
        chk({name, "_cnt"}, stall_cycles, m_cnt);
        @(posedge clk);
        if (v.rst) begin
            m_busy = 0;
            m_cnt  = 0;
        end else begin
            if (e[5]) m_cnt++;
            if (!(v.mreq && !v.mrdy)) begin
                if (m_busy > 0) m_busy--;
                else if (!v.br && !is_lu(v) && v.is_mul) m_busy = MUL_LAT - 1;
            end
        end
        #1;
    endtask

    vec_t tbl[9];
    in_t  idle, rstv, v;
    logic [10:0] obs;
    int unsigned c0;

    initial begin
        idle = '{default: '0, mrdy: 1'b1};
        rstv = idle; rstv.rst = 1'b1;

        tbl[0] = '{idle, 11'b00000000000};
        v = idle; v.xw = 1; v.xrd = 5; v.mw = 1; v.mrd = 5; v.rt = 5; v.uses_rt = 1;
        tbl[1] = '{v, 11'b00101000000};
        v.xrd = 0; v.mrd = 0; v.rt = 0;
        tbl[2] = '{v, 11'b00000000000};
        v = idle; v.xmr = 1; v.xw = 1; v.xrd = 8; v.rs = 8; v.uses_rs = 1;
        tbl[3] = '{v, 11'b10000110000};
        v.br = 1;
        tbl[4] = '{v, 11'b10000000001};
        v = idle; v.mreq = 1; v.mrdy = 0;
        tbl[5] = '{v, 11'b00000111100};
        v = idle; v.xw = 1; v.xrd = 3; v.rs = 3;
        tbl[6] = '{v, 11'b00000000000};
        v = idle; v.mw = 1; v.mrd = 7; v.rs = 7; v.uses_rs = 1;
        tbl[7] = '{v, 11'b00010000000};
        v = idle; v.xw = 1; v.xrd = 9; v.rs = 9; v.rt = 9; v.uses_rs = 1; v.uses_rt = 1;
        tbl[8] = '{v, 11'b01100000000};

        // Reset with live hazards on the inputs: every output stays low.
        drive(rstv);
        @(posedge clk); #1;
        v = tbl[1].v; v.rst = 1; v.mreq = 1; v.mrdy = 0; v.br = 1;
        run_cycle("reset", v, obs);
        chk("reset_zero", 32'(obs), 32'd0);

        foreach (tbl[i]) begin
            run_cycle("tbl", tbl[i].v, obs);
            chk($sformatf("tbl%0d", i), 32'(obs), 32'(tbl[i].exp));
        end

        // Load-use: one bubble, then clear, counter +1.
        run_cycle("rst1", rstv, obs);
        run_cycle("lu", tbl[3].v, obs);
        run_cycle("lu_after", idle, obs);
        chk("lu_after_zero", 32'(obs), 32'd0);
        chk("lu_cnt", stall_cycles, 32'd1);

        // Multiply: three busy cycles with hold_x/bubble_m, then RUN.
        run_cycle("rst2", rstv, obs);
        v = idle; v.is_mul = 1;
        run_cycle("mul_issue", v, obs);
        for (int unsigned k = 0; k < 3; k++) begin
            run_cycle("mul_busy", idle, obs);
            chk("mul_busy_bits", 32'(obs), 32'(11'b00000111010));
        end
        run_cycle("mul_done", idle, obs);
        chk("mul_done_zero", 32'(obs), 32'd0);
        chk("mul_cnt", stall_cycles, 32'd3);

        // Multiply stretched by a two-cycle memory wait.
        run_cycle("rst3", rstv, obs);
        v = idle; v.is_mul = 1;
        run_cycle("mw_issue", v, obs);
        run_cycle("mw_busy", idle, obs);
        v = idle; v.mreq = 1; v.mrdy = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            run_cycle("mw_wait", v, obs);
            chk("mw_wait_bits", 32'(obs), 32'(11'b00000111100));
        end
        run_cycle("mw_busy2", idle, obs);
        run_cycle("mw_busy3", idle, obs);
        chk("mw_busy3_bits", 32'(obs), 32'(11'b00000111010));
        run_cycle("mw_done", idle, obs);
        chk("mw_done_zero", 32'(obs), 32'd0);
        chk("mw_cnt", stall_cycles, 32'd5);

        // Reset in the middle of a multiply aborts it.
        v = idle; v.is_mul = 1;
        run_cycle("rm_issue", v, obs);
        run_cycle("rm_busy", idle, obs);
        run_cycle("rm_rst", rstv, obs);
        run_cycle("rm_after", idle, obs);
        chk("rm_after_zero", 32'(obs), 32'd0);
        chk("rm_cnt", stall_cycles, 32'd0);

        // Squashed multiply (branch) does not start the countdown.
        v = idle; v.is_mul = 1; v.br = 1;
        run_cycle("sq_br", v, obs);
        run_cycle("sq_after", idle, obs);
        chk("sq_after_zero", 32'(obs), 32'd0);

        // Randomized traffic against the model.
        c0 = 0;
        for (int unsigned n = 0; n < 400; n++) begin
            v.rst     = ($urandom_range(31) == 0);
            v.rs      = 5'($urandom_range(3));
            v.rt      = 5'($urandom_range(3));
            v.uses_rs = 1'($urandom);
            v.uses_rt = 1'($urandom);
            v.is_mul  = ($urandom_range(5) == 0);
            v.xrd     = 5'($urandom_range(3));
            v.xw      = 1'($urandom);
            v.xmr     = ($urandom_range(3) == 0);
            v.br      = ($urandom_range(7) == 0);
            v.mrd     = 5'($urandom_range(3));
            v.mw      = 1'($urandom);
            v.mreq    = 1'($urandom);
            v.mrdy    = ($urandom_range(3) != 0);
            run_cycle("rand", v, obs);
            c0++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage core. It drives the D→X forwarding mux and the pipeline-register enables:
- bubble and forwarding selects into the X-stage input;
- hold/flush controls for F/D, D/X, X/M and M/W.

It resolves load-use hazards, taken-branch flushes, multi-cycle multiplies in X, and M-stage memory wait states. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- MUL_LAT, 4: X-stage multiply latency in cycles; legal range 1–15; 1 means single-cycle.
- CNT_W, 32: width of the stall performance counter.

Ports (Signal = 1-bit, RegAddr = 5-bit, both from `definitions`):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- dx_rs_addr  in  5  rs address of the instruction in the D/X register.
- dx_rt_addr  in  5  rt address of the instruction in the D/X register.
- dx_uses_rs  in  1  the D/X instruction reads rs.
- dx_uses_rt  in  1  the D/X instruction reads rt.
- dx_is_mul  in  1  the D/X instruction is a multiply.
- x_rd_addr  in  5  destination of the instruction in X.
- x_reg_write  in  1  the X instruction writes the register file.
- x_mem_read  in  1  the X instruction is a load.
- x_branch_taken  in  1  the branch in X resolved taken.
- m_rd_addr  in  5  destination of the instruction in M.
- m_reg_write  in  1  the M instruction writes the register file.
- m_mem_req  in  1  the M stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- stall  out  1  bubble into X (zeroes the X input).
- fwdX_rs, fwdX_rt  out  1  forward the X result to rs / rt.
- fwdM_rs, fwdM_rt  out  1  forward the M result to rs / rt.
- hold_fd  out  1  PC and F/D register keep their value.
- hold_dx  out  1  D/X register keeps its value.
- hold_x  out  1  X-stage register keeps its value.
- hold_m  out  1  M-stage register keeps its value.
- bubble_m  out  1  load a bubble into M.
- flush_fd  out  1  load zero into F/D.
- stall_cycles  out  CNT_W  count of cycles with hold_fd=1; wraps modulo 2^CNT_W.

## Operation
Match terms:
- matchX(a) = x_reg_write & (x_rd_addr≠0) & (x_rd_addr==a).
- matchM(a) = m_reg_write & (m_rd_addr≠0) & (m_rd_addr==a).
- The source address a is gated by the corresponding dx_uses_* bit.

Forwarding (combinational; asserted in every mode except reset):
- fwdX_rs = matchX(rs) & ~x_mem_read; fwdX_rt likewise for rt.
- fwdM_rs = matchM(rs); fwdM_rt likewise for rt.
- X and M selects may both be 1; the consumer gives X priority.

Load-use condition: lu = x_mem_read & (matchX(rs) | matchX(rt)).

State: mode ∈ {RUN, MUL_BUSY}, plus mul_cnt[3:0]. Outputs are combinational from mode, mul_cnt and inputs. Priority, highest first:
1. rst: all outputs 0 except stall_cycles.
2. Memory wait (m_mem_req & ~mem_ready): hold_fd = hold_dx = hold_x = hold_m = 1; stall, bubble_m, flush_fd = 0. mul_cnt and mode are frozen.
3. MUL_BUSY: hold_fd = hold_dx = hold_x = 1, bubble_m = 1, hold_m = 0. mul_cnt decrements each cycle; at mul_cnt==1 the next mode is RUN.
4. x_branch_taken: flush_fd = 1, stall = 1; no holds.
5. lu: stall = 1, hold_fd = 1, hold_dx = 1 for one cycle. The bubble then clears lu naturally.
6. Otherwise: all controls 0.

Multiply issue:
- Condition: mode RUN, dx_is_mul=1, and no rule 2, 4 or 5 in this cycle.
- If MUL_LAT>1: next mode = MUL_BUSY and mul_cnt = MUL_LAT−1.
- If MUL_LAT=1: mode stays RUN.
- A multiply that is squashed by a branch or load-use does not start the counter.

Counter and reset behaviour:
- stall_cycles increments on every non-reset cycle with hold_fd=1.
- Reset: mode = RUN, mul_cnt = 0, stall_cycles = 0. Reset asserted mid-multiply or mid-wait aborts the operation immediately.

## Timing
- Forwarding, stall, hold, flush and bubble outputs are zero-latency combinational; they are valid in the same cycle as their inputs.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 2 slots: F/D is flushed and X gets a bubble.
- Multiply: the multiply occupies X for MUL_LAT cycles. Its result is forwarded via fwdX on the final cycle, with no extra stall.
- Memory wait stalls the pipe for as many cycles as mem_ready stays low. When the wait coincides with MUL_BUSY, the wait cycles add to the multiply time because mul_cnt is frozen.
- mode, mul_cnt and stall_cycles update on the rising edge of clk.

## Structure
- Add to package `definitions`:
  - `typedef enum logic {RUN, MUL_BUSY} hz_mode_t`;
  - `typedef logic [4:0] RegAddr`, if not already present.
- Add a single sub-module `fwd_match` (address compare producing matchX/matchM), instantiated once per source operand.

## Test plan
- Load r8 in X (x_mem_read=1, x_rd_addr=8) and dx_rs_addr=8, dx_uses_rs=1 → exactly 1 cycle with stall=hold_fd=hold_dx=1; next cycle all 0; stall_cycles=1.
- x_reg_write=1, x_rd_addr=5 and m_reg_write=1, m_rd_addr=5, dx_rt_addr=5 → fwdX_rt=1 and fwdM_rt=1. Repeat with address 0 → all forwarding selects 0.
- MUL_LAT=4, issue a multiply → 3 cycles MUL_BUSY with hold_x=bubble_m=1, then RUN; stall_cycles=3.
- Taken branch in X with lu also true → flush_fd=1, stall=1, hold_fd=0.
- Multiply busy at mul_cnt=2, then mem_ready low for 2 cycles → hold_m=1 and mul_cnt stays 2; total hold_fd cycles = 5.
- Assert rst during MUL_BUSY → next cycle mode=RUN, all outputs 0, stall_cycles=0.
